// File: rtl/geofence_pkg.sv
// rtl/geofence_pkg.sv - shared widths, FSM encoding and point helpers for the geofence engine
// A point is packed {x, y}, COORD_W bits each, unsigned.
// A vector is packed {dx, dy}, VEC_W bits each, two's complement.
package geofence_pkg;

  localparam int NUM_FENCE  = 6;
  localparam int NUM_PTS    = NUM_FENCE + 1;
  localparam int COORD_W    = 10;
  localparam int VEC_W      = 11;
  localparam int PT_W       = 2 * COORD_W;
  localparam int CV_W       = 2 * VEC_W;
  localparam int PT_BUS_W   = NUM_PTS * PT_W;
  localparam int SORT_BUS_W = (NUM_FENCE - 1) * PT_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SORT_REQ  = 3'd2,
    S_SORT_WAIT = 3'd3,
    S_TEST      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  function automatic logic [PT_W-1:0] pack_pt(input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [COORD_W-1:0] pt_x(input logic [PT_W-1:0] p);
    return p[PT_W-1:COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] pt_y(input logic [PT_W-1:0] p);
    return p[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/vec_diff.sv
// rtl/vec_diff.sv - component-wise difference of two points as a signed vector
// Ports:
//   a    in  PT_W  minuend point {x,y}
//   b    in  PT_W  subtrahend point {x,y}
//   diff out CV_W  {a.x-b.x, a.y-b.y}, each VEC_W-bit two's complement
// Zero-extending both operands by one bit makes the result exact: no overflow
// is possible for 10-bit unsigned inputs.
module vec_diff
  import geofence_pkg::*;
(
  input  logic [PT_W-1:0] a,
  input  logic [PT_W-1:0] b,
  output logic [CV_W-1:0] diff
);

  logic [VEC_W-1:0] dx;
  logic [VEC_W-1:0] dy;

  assign dx   = {1'b0, pt_x(a)} - {1'b0, pt_x(b)};
  assign dy   = {1'b0, pt_y(a)} - {1'b0, pt_y(b)};
  assign diff = {dx, dy};

endmodule

// File: rtl/geofence_ctrl.sv
// rtl/geofence_ctrl.sv - geofence sequencer: load points, request sort, walk fence edges
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   in_valid, X, Y    serial point input (object first, then G1..G6)
//   pt_bus            seven stored points, [19:0]=object, [39:20]=G1 .. [139:120]=G6
//   sort_start        one-cycle request to the angular sorter
//   sort_done         sorter completion pulse (only honoured while waiting)
//   sorted_bus        sorter output G2..G6, packed like pt_bus
//   cp_v1, cp_v2      vectors to the shared cross-product unit, zero outside TEST
//   cp_cw             orientation answer for (cp_v1, cp_v2), same cycle
//   busy, valid       job in progress / one-cycle result strobe
//   is_inside         result, held until the next valid
// Build option: GEOFENCE_EARLY_EXIT_EN ends the edge walk at the first edge
// whose orientation disagrees with edge 0.
module geofence_ctrl
  import geofence_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [COORD_W-1:0]    X,
  input  logic [COORD_W-1:0]    Y,
  output logic [PT_BUS_W-1:0]   pt_bus,
  output logic                  sort_start,
  input  logic                  sort_done,
  input  logic [SORT_BUS_W-1:0] sorted_bus,
  output logic [CV_W-1:0]       cp_v1,
  output logic [CV_W-1:0]       cp_v2,
  input  logic                  cp_cw,
  output logic                  busy,
  output logic                  valid,
  output logic                  is_inside
);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            k_q, k_d;
  logic [PT_BUS_W-1:0]   pt_q, pt_d;
  logic                  ref_q, ref_d;
  logic                  flag_q, flag_d;
  logic                  sort_start_q, sort_start_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  is_inside_q, is_inside_d;

  logic [PT_W-1:0]       obj_pt;
  logic [PT_W-1:0]       f_cur;
  logic [PT_W-1:0]       f_nxt;
  logic                  mismatch;
  logic                  last_edge;
  logic                  finish;

  // Operands are forced to zero outside TEST so both vectors read as zero.
  always_comb begin
    obj_pt = '0;
    f_cur  = '0;
    f_nxt  = '0;
    if (state_q == S_TEST) begin
      obj_pt = pt_q[PT_W-1:0];
      for (int i = 0; i < NUM_FENCE; i++) begin
        if (k_q == 3'(i)) begin
          f_cur = pt_q[(i + 1) * PT_W +: PT_W];
          // Edge from the last fence point closes back onto G1.
          f_nxt = pt_q[(((i + 1) % NUM_FENCE) + 1) * PT_W +: PT_W];
        end
      end
    end
  end

  vec_diff u_v1 (
    .a    (f_cur),
    .b    (obj_pt),
    .diff (cp_v1)
  );

  vec_diff u_v2 (
    .a    (f_nxt),
    .b    (f_cur),
    .diff (cp_v2)
  );

  // Edge 0 defines the reference orientation, so it can never mismatch.
  assign mismatch = (k_q != 3'd0) && (cp_cw != ref_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    pt_d         = pt_q;
    ref_d        = ref_q;
    flag_d       = flag_q;
    sort_start_d = 1'b0;
    busy_d       = busy_q;
    valid_d      = 1'b0;
    is_inside_d  = is_inside_q;
    last_edge    = 1'b0;
    finish       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pt_d[PT_W-1:0] = pack_pt(X, Y);
          cnt_d          = 3'd1;
          busy_d         = 1'b1;
          state_d        = S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          for (int i = 1; i < NUM_PTS; i++) begin
            if (cnt_q == 3'(i)) begin
              pt_d[i * PT_W +: PT_W] = pack_pt(X, Y);
            end
          end
          if (cnt_q == 3'(NUM_FENCE)) begin
            cnt_d        = 3'd0;
            sort_start_d = 1'b1;
            state_d      = S_SORT_REQ;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      S_SORT_REQ: begin
        state_d = S_SORT_WAIT;
      end

      S_SORT_WAIT: begin
        if (sort_done) begin
          // G1 is the sort anchor and is never reordered.
          pt_d[PT_BUS_W-1:2*PT_W] = sorted_bus;
          k_d                     = 3'd0;
          state_d                 = S_TEST;
        end
      end

      S_TEST: begin
        last_edge = (k_q == 3'(NUM_FENCE - 1));
        if (k_q == 3'd0) begin
          ref_d  = cp_cw;
          flag_d = 1'b1;
        end else if (mismatch) begin
          flag_d = 1'b0;
        end
`ifdef GEOFENCE_EARLY_EXIT_EN
        finish = last_edge || mismatch;
`else
        finish = last_edge;
`endif
        if (finish) begin
          // flag_q is stale only at k=0, which can never be the final edge.
          is_inside_d = flag_q & ~mismatch;
          valid_d     = 1'b1;
          busy_d      = 1'b0;
          k_d         = 3'd0;
          state_d     = S_DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      k_q          <= 3'd0;
      pt_q         <= '0;
      ref_q        <= 1'b0;
      flag_q       <= 1'b0;
      sort_start_q <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      is_inside_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      pt_q         <= pt_d;
      ref_q        <= ref_d;
      flag_q       <= flag_d;
      sort_start_q <= sort_start_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      is_inside_q  <= is_inside_d;
    end
  end

  assign pt_bus     = pt_q;
  assign sort_start = sort_start_q;
  assign busy       = busy_q;
  assign valid      = valid_q;
  assign is_inside  = is_inside_q;

endmodule
